// File: rtl/l2c_line_mem_model_if.sv
// Request/answer bus between the L2 cache arbiter (master) and the L2 line memory model (slave).
interface l2c_line_mem_model_if #(
  parameter int LINE_W = 512,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic              req_valid_i;
  logic              req_rdy_o;
  logic [1:0]        req_cmd_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [LINE_W-1:0] req_line_i;
  logic [ID_W-1:0]   req_id_i;
  logic              ans_valid_o;
  logic              ans_rdy_i;
  logic [1:0]        ans_cmd_o;
  logic [ADDR_W-1:0] ans_addr_o;
  logic [ID_W-1:0]   ans_id_o;
  logic [LINE_W-1:0] ans_line_o;
  logic              ans_err_o;

  modport master (
    output req_valid_i, req_cmd_i, req_addr_i, req_line_i, req_id_i, ans_rdy_i,
    input  req_rdy_o, ans_valid_o, ans_cmd_o, ans_addr_o, ans_id_o, ans_line_o, ans_err_o
  );

  modport slave (
    input  req_valid_i, req_cmd_i, req_addr_i, req_line_i, req_id_i, ans_rdy_i,
    output req_rdy_o, ans_valid_o, ans_cmd_o, ans_addr_o, ans_id_o, ans_line_o, ans_err_o
  );
endinterface

// File: rtl/l2c_line_mem_model.sv
// L2-side line memory model: request FIFO, fixed-latency service FSM, answer held until accepted.
module l2c_line_mem_model #(
  parameter int LINE_W    = 512,
  parameter int ADDR_W    = 32,
  parameter int MEM_LINES = 1024,
  parameter int DEPTH     = 4,
  parameter int LATENCY   = 5,
  parameter int ID_W      = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic flush_i,
  l2c_line_mem_model_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef struct packed {
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] line;
    logic [ID_W-1:0]   id;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ANSWER
  } state_t;

  state_t            state_q, state_d;
  req_t              fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    occ_q;
  logic [CNT_W-1:0]  cnt_q;
  req_t              work_q;
  logic [LINE_W-1:0] mem [MEM_LINES];

  logic              fifo_full, fifo_empty, push, pop, exec;
  logic              exec_err, mem_wr, is_read;
  logic [IDX_W-1:0]  idx;

  logic [1:0]        ans_cmd_q;
  logic [ADDR_W-1:0] ans_addr_q;
  logic [ID_W-1:0]   ans_id_q;
  logic [LINE_W-1:0] ans_line_q;
  logic              ans_err_q;

  assign fifo_full      = (occ_q == (PTR_W+1)'(DEPTH));
  assign fifo_empty     = (occ_q == '0);
  assign bus.req_rdy_o  = !fifo_full && !flush_i;
  assign push           = bus.req_valid_i && bus.req_rdy_o;
  assign pop            = (state_q == S_IDLE) && !fifo_empty && !flush_i;

  assign idx      = work_q.addr[IDX_W-1:0];
  assign exec_err = work_q.cmd[1] || ({1'b0, work_q.addr} >= (ADDR_W+1)'(MEM_LINES));
  assign is_read  = (work_q.cmd == 2'b00);
  assign mem_wr   = exec && !exec_err && (work_q.cmd == 2'b01);

  // NOTE: storage arrays carry no reset; only pointers and control flops are reset.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= '{cmd: bus.req_cmd_i, addr: bus.req_addr_i,
                                       line: bus.req_line_i, id: bus.req_id_i};
  end

  always_ff @(posedge clk_i) begin
    if (mem_wr) mem[idx] <= work_q.line;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + (PTR_W+1)'(1);
        2'b01:   occ_q <= occ_q - (PTR_W+1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: defaults first so no path through this block leaves a latch behind.
  always_comb begin
    state_d = state_q;
    exec    = 1'b0;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   if (!fifo_empty) state_d = S_WAIT;
        S_WAIT:   if (cnt_q == '0) begin
                    state_d = S_ANSWER;
                    exec    = 1'b1;
                  end
        S_ANSWER: if (bus.ans_rdy_i) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q      <= '0;
      work_q     <= '0;
      ans_cmd_q  <= '0;
      ans_addr_q <= '0;
      ans_id_q   <= '0;
      ans_line_q <= '0;
      ans_err_q  <= 1'b0;
    end else if (flush_i) begin
      cnt_q      <= '0;
      ans_cmd_q  <= '0;
      ans_addr_q <= '0;
      ans_id_q   <= '0;
      ans_line_q <= '0;
      ans_err_q  <= 1'b0;
    end else begin
      if (pop) begin
        work_q <= fifo_mem[rd_ptr_q];
        cnt_q  <= CNT_W'(LATENCY - 1);
      end else if (state_q == S_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (exec) begin
        ans_cmd_q  <= work_q.cmd;
        ans_addr_q <= work_q.addr;
        ans_id_q   <= work_q.id;
        ans_err_q  <= exec_err;
        // Writes and rejected requests answer with an all-zero line.
        ans_line_q <= (is_read && !exec_err) ? mem[idx] : '0;
      end
    end
  end

  assign bus.ans_valid_o = (state_q == S_ANSWER);
  assign bus.ans_cmd_o   = ans_cmd_q;
  assign bus.ans_addr_o  = ans_addr_q;
  assign bus.ans_id_o    = ans_id_q;
  assign bus.ans_line_o  = ans_line_q;
  assign bus.ans_err_o   = ans_err_q;

endmodule

// File: tb/tb_l2c_line_mem_model.sv
// Directed bench for l2c_line_mem_model: transaction-level model plus per-cycle answer comparison.
module tb_l2c_line_mem_model;

  localparam int LINE_W    = 512;
  localparam int ADDR_W    = 32;
  localparam int MEM_LINES = 1024;
  localparam int ID_W      = 4;

  typedef struct {
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [LINE_W-1:0] line;
  } req_t;

  typedef struct {
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [LINE_W-1:0] line;
    logic              err;
  } ans_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  int vectors    = 0;
  int miscompares = 0;

  req_t              pend_q[$];
  ans_t              log_q[$];
  ans_t              exp_cur;
  bit                prev_valid = 1'b0;
  logic [LINE_W-1:0] mmem [int];

  l2c_line_mem_model_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

  l2c_line_mem_model dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Spec-level execution of one request against the reference memory.
  function automatic ans_t model_exec(input req_t r);
    ans_t a;
    int   i;
    a.cmd  = r.cmd;
    a.addr = r.addr;
    a.id   = r.id;
    a.err  = (r.cmd > 2'b01) || (r.addr >= MEM_LINES);
    a.line = '0;
    i      = int'(r.addr % MEM_LINES);
    if (!a.err) begin
      if (r.cmd == 2'b00) a.line = mmem.exists(i) ? mmem[i] : '0;
      else                mmem[i] = r.line;
    end
    return a;
  endfunction

  // Inputs change only at posedge+1, so negedge values are exactly what the next edge sees.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_q.delete();
      prev_valid = 1'b0;
    end else begin
      if (bus.ans_valid_o) begin
        if (!prev_valid) begin
          if (pend_q.size() == 0) begin
            check("unexpected_answer", 1, 0);
            exp_cur = '{bus.ans_cmd_o, bus.ans_addr_o, bus.ans_id_o, bus.ans_line_o, bus.ans_err_o};
          end else begin
            exp_cur = model_exec(pend_q[0]);
          end
        end
        check("ans_cmd",  bus.ans_cmd_o,  exp_cur.cmd);
        check("ans_addr", bus.ans_addr_o, exp_cur.addr);
        check("ans_id",   bus.ans_id_o,   exp_cur.id);
        check("ans_err",  bus.ans_err_o,  exp_cur.err);
        check("ans_line", bus.ans_line_o, exp_cur.line);
        if (bus.ans_rdy_i && !flush) begin
          log_q.push_back('{bus.ans_cmd_o, bus.ans_addr_o, bus.ans_id_o, bus.ans_line_o, bus.ans_err_o});
          if (pend_q.size() > 0) void'(pend_q.pop_front());
        end
      end
      prev_valid = bus.ans_valid_o && !bus.ans_rdy_i && !flush;
      if (flush) pend_q.delete();
      if (bus.req_valid_i && bus.req_rdy_o)
        pend_q.push_back('{bus.req_cmd_i, bus.req_addr_i, bus.req_id_i, bus.req_line_i});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one request and hold it until accepted; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr,
                      input logic [LINE_W-1:0] line, input logic [ID_W-1:0] id);
    bit done = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_cmd_i   = cmd;
    bus.req_addr_i  = addr;
    bus.req_line_i  = line;
    bus.req_id_i    = id;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (bus.req_rdy_o) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.req_valid_i = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  // Returns at the first negedge with ans_valid_o high.
  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (bus.ans_valid_o) seen = 1'b1;
    end
    if (!seen) check(name, 0, 1);
  endtask

  task automatic drain();
    bit idle = 1'b0;
    for (int k = 0; k < 400 && !idle; k++) begin
      @(negedge clk);
      if (pend_q.size() == 0 && !bus.ans_valid_o) idle = 1'b1;
    end
    if (!idle) check("drain_timeout", 0, 1);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] pat_a5, pat_5a, pat_11, pat_22, pat_ff;
    bit                rdy_rec [6];
    int                lat, base;
    bit                seen;

    pat_a5 = {64{8'hA5}};
    pat_5a = {64{8'h5A}};
    pat_11 = {64{8'h11}};
    pat_22 = {64{8'h22}};
    pat_ff = {64{8'hFF}};

    rst_n           = 1'b0;
    flush           = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_cmd_i   = '0;
    bus.req_addr_i  = '0;
    bus.req_line_i  = '0;
    bus.req_id_i    = '0;
    bus.ans_rdy_i   = 1'b0;
    #2;
    check("rst_req_rdy",   bus.req_rdy_o,   1);
    check("rst_ans_valid", bus.ans_valid_o, 0);
    check("rst_ans_cmd",   bus.ans_cmd_o,   0);
    check("rst_ans_addr",  bus.ans_addr_o,  0);
    check("rst_ans_id",    bus.ans_id_o,    0);
    check("rst_ans_line",  bus.ans_line_o,  0);
    check("rst_ans_err",   bus.ans_err_o,   0);
    step();
    step();
    rst_n = 1'b1;
    step();
    bus.ans_rdy_i = 1'b1;

    // Write then read, with first-answer latency.
    send(2'b01, 32'h10, pat_a5, 4'd3);
    lat  = -1;
    seen = 1'b0;
    for (int k = 1; k <= 30 && !seen; k++) begin
      @(negedge clk);
      if (bus.ans_valid_o) begin
        seen = 1'b1;
        lat  = k - 1;
      end
    end
    check("wr_latency", lat, 6);
    check("wr_id",   bus.ans_id_o,   3);
    check("wr_line", bus.ans_line_o, 0);
    check("wr_err",  bus.ans_err_o,  0);
    step();
    send(2'b00, 32'h10, '0, 4'd4);
    wait_valid("rd_timeout");
    check("rd_line", bus.ans_line_o, pat_a5);
    check("rd_id",   bus.ans_id_o,   4);
    step();
    drain();

    // Backpressure: answer held 10 cycles, then exactly one handshake.
    bus.ans_rdy_i = 1'b0;
    send(2'b00, 32'h10, '0, 4'd5);
    wait_valid("bp_timeout");
    base = log_q.size();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", bus.ans_valid_o, 1);
      check("bp_line",  bus.ans_line_o,  pat_a5);
      check("bp_id",    bus.ans_id_o,    5);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.ans_rdy_i = 1'b1;
    @(negedge clk);
    check("bp_valid_release", bus.ans_valid_o, 1);
    @(negedge clk);
    check("bp_valid_after", bus.ans_valid_o, 0);
    check("bp_one_handshake", log_q.size(), base + 1);
    step();
    drain();

    // FIFO full: 4 queued plus one in service, sixth refused until space frees.
    bus.ans_rdy_i = 1'b0;
    base = log_q.size();
    for (int i = 0; i < 6; i++) begin
      bus.req_valid_i = 1'b1;
      bus.req_cmd_i   = 2'b00;
      bus.req_addr_i  = 32'h10;
      bus.req_line_i  = '0;
      bus.req_id_i    = ID_W'(8 + i);
      @(negedge clk);
      rdy_rec[i] = bus.req_rdy_o;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 6; i++) check($sformatf("full_rdy%0d", i), rdy_rec[i], (i < 5) ? 1 : 0);
    bus.ans_rdy_i = 1'b1;
    send(2'b00, 32'h10, '0, 4'd13);
    drain();
    check("full_count", log_q.size(), base + 6);
    for (int i = 0; i < 6 && base + i < log_q.size(); i++)
      check($sformatf("full_order%0d", i), log_q[base + i].id, 8 + i);

    // Illegal command and out-of-range address.
    base = log_q.size();
    send(2'b01, 32'h0, pat_5a, 4'd1);
    send(2'b10, 32'h0, pat_ff, 4'd2);
    send(2'b00, 32'(MEM_LINES), '0, 4'd3);
    send(2'b00, 32'h0, '0, 4'd4);
    drain();
    check("err_count", log_q.size(), base + 4);
    if (log_q.size() >= base + 4) begin
      check("err_cmd_err",   log_q[base + 1].err,  1);
      check("err_cmd_line",  log_q[base + 1].line, 0);
      check("err_addr_err",  log_q[base + 2].err,  1);
      check("err_addr_line", log_q[base + 2].line, 0);
      check("err_line0_err", log_q[base + 3].err,  0);
      check("err_line0",     log_q[base + 3].line, pat_5a);
    end

    // Flush while a write is in WAIT with two reads queued.
    send(2'b01, 32'h5, pat_11, 4'd1);
    drain();
    base = log_q.size();
    send(2'b01, 32'h5, pat_22, 4'd2);
    send(2'b00, 32'h5, '0, 4'd3);
    send(2'b00, 32'h5, '0, 4'd4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("fl_valid", bus.ans_valid_o, 0);
    check("fl_rdy",   bus.req_rdy_o,   1);
    check("fl_id",    bus.ans_id_o,    0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("fl_no_answer", bus.ans_valid_o, 0);
    end
    check("fl_log", log_q.size(), base);
    step();
    send(2'b00, 32'h5, '0, 4'd5);
    drain();
    check("fl_old_data", log_q[log_q.size() - 1].line, pat_11);

    // Asynchronous reset in ANSWER.
    bus.ans_rdy_i = 1'b0;
    send(2'b00, 32'h10, '0, 4'd6);
    wait_valid("rst_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.ans_valid_o, 0);
    check("arst_id",    bus.ans_id_o,    0);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_rdy", bus.req_rdy_o, 1);
    step();
    bus.ans_rdy_i = 1'b1;
    send(2'b00, 32'h10, '0, 4'd7);
    drain();
    check("arst_after_id",   log_q[log_q.size() - 1].id,   7);
    check("arst_after_line", log_q[log_q.size() - 1].line, pat_a5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
